// File: rtl/noc_pkg.sv
// Shared definitions for the NoC output-port arbiter.
//   DEFAULT_DATA_WIDTH : default flit width in bits
//   TAIL_BIT           : tail-flag position for the default flit width
//   arb_state_t        : arbiter FSM encoding (IDLE, LOCKED)
//   tail_bit_of()      : tail-flag position for an arbitrary flit width
//   ptr_width()        : width of a requester index (at least 1 bit)
package noc_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned TAIL_BIT           = DEFAULT_DATA_WIDTH - 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int unsigned tail_bit_of(input int unsigned width);
    return width - 1;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_port_arbiter_rr_priority_picker.sv
// Rotating-priority picker (purely combinational).
// Selects the first set bit of req, searching from index rr_ptr upward and
// wrapping modulo NUM_REQ.
//   req    : request vector, one bit per requester
//   rr_ptr : index holding highest priority
//   pick   : one-hot selected requester, all-zero when nothing requests
//   valid  : at least one requester is active
module rr_priority_picker
  import noc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_pick;

  // Rotate right so rr_ptr lands on bit 0, isolate the lowest set bit with
  // x & -x, then rotate back (right by NUM_REQ - rr_ptr == left by rr_ptr).
  always_comb begin
    rot      = NUM_REQ'({req, req} >> rr_ptr);
    rot_pick = rot & (~rot + 1'b1);
    pick     = NUM_REQ'({rot_pick, rot_pick} >> (NUM_REQ - 32'(rr_ptr)));
    valid    = |req;
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Wormhole output-port arbiter for a NoC router.
// Several requester FIFOs (first-word-fall-through) share one registered
// output port. A packet owner is chosen by rotating priority and keeps the
// port until its tail flit (bit DATA_WIDTH-1) has been popped.
//   clk, rst   : clock, asynchronous active-high reset
//   req_empty  : per-requester FIFO empty flags
//   req_data   : per-requester head flits, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_rd_en  : per-requester pop strobe (combinational)
//   out_valid  : output register holds a flit
//   out_data   : output flit
//   out_ready  : downstream accepts out_data this cycle
//   grant      : one-hot current packet owner, all-zero when idle
//   busy       : a packet is locked onto the port
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rd_en,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);
  localparam int unsigned TAIL  = tail_bit_of(DATA_WIDTH);

  arb_state_t         state;
  arb_state_t         state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [PTR_W-1:0]   g_idx;
  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic [DATA_WIDTH-1:0] head;
  logic               head_avail;
  logic               pop;
  logic               tail_pop;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (~req_empty),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .valid  (pick_valid)
  );

  // Granted index and its head flit, decoded from the one-hot grant.
  always_comb begin
    g_idx = '0;
    head  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_idx = PTR_W'(i);
        head  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    if (32'(g_idx) == NUM_REQ - 1) begin
      rr_ptr_next = '0;
    end else begin
      rr_ptr_next = g_idx + 1'b1;
    end
  end

  // A pop needs a locked owner with data and room in the output register
  // (empty, or being drained this cycle). An empty owner FIFO simply stalls
  // the lock; the grant never moves mid-packet.
  assign head_avail = |(grant & ~req_empty);
  assign pop        = (state == LOCKED) && head_avail && (!out_valid || out_ready);
  assign tail_pop   = pop && head[TAIL];
  assign req_rd_en  = (pop && !rst) ? grant : '0;
  assign busy       = (state == LOCKED);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pick_valid) state_next = LOCKED;
      LOCKED:  if (tail_pop)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else if ((state == IDLE) && pick_valid) begin
      grant <= pick;
    end else if (tail_pop) begin
      grant  <= '0;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= head;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter (DATA_WIDTH=16, NUM_REQ=4) with
// behavioural FWFT requester FIFOs.
module tb_noc_port_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_empty;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_rd_en;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;
  logic [NR-1:0]    grant;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[NR][$];
  logic [15:0] exp_q[NR][$];
  logic [15:0] got[$];
  logic [15:0] want[$];

  noc_port_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_empty (req_empty),
    .req_data  (req_data),
    .req_rd_en (req_rd_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      req_empty[i] = (q[i].size() == 0);
      req_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : 16'h0000;
    end
  endtask

  task automatic push(input int r, input logic [15:0] f);
    q[r].push_back(f);
    refresh();
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick();
    logic [NR-1:0] rd;
    #1;
    rd = req_rd_en;
    chk("rd_onehot", 32'($onehot0(rd)), 32'd1);
    chk("rd_on_empty", 32'(rd & req_empty), 32'd0);
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (rd[i] && q[i].size() != 0) void'(q[i].pop_front());
    refresh();
    @(negedge clk);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++)
      if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int limit, input bit rand_ready);
    bit done;
    done = 1'b0;
    for (int n = 0; n < limit && !done; n++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      done = all_empty() && !out_valid && !busy;
    end
    out_ready = 1'b1;
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk(tag, 32'(got[i]), 32'(want[i]));
    got.delete();
    want.delete();
  endtask

  initial begin
    int          owner;
    int          r;
    int          total;
    int unsigned len;
    logic [15:0] f;

    rst       = 1'b1;
    out_ready = 1'b1;
    req_empty = '1;
    req_data  = '0;
    refresh();
    @(negedge clk);

    // Reset state
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_rd_en", 32'(req_rd_en), 32'd0);

    // Single requester, 3-flit packet
    push(1, 16'h0011);
    push(1, 16'h0022);
    push(1, 16'h8033);
    #1;
    chk("rst_rd_en_nonempty", 32'(req_rd_en), 32'd0);
    chk("rst_grant_nonempty", 32'(grant), 32'd0);
    rst = 1'b0;
    tick();
    chk("t1_grant_c1", 32'(grant), 32'h2);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_valid_c1", 32'(out_valid), 32'd0);
    chk("t1_rd_c1", 32'(req_rd_en), 32'h2);
    tick();
    chk("t1_valid_c2", 32'(out_valid), 32'd1);
    chk("t1_data_c2", 32'(out_data), 32'h0011);
    chk("t1_grant_c2", 32'(grant), 32'h2);
    tick();
    chk("t1_data_c3", 32'(out_data), 32'h0022);
    chk("t1_grant_c3", 32'(grant), 32'h2);
    tick();
    chk("t1_data_c4", 32'(out_data), 32'h8033);
    chk("t1_valid_c4", 32'(out_valid), 32'd1);
    chk("t1_grant_c4", 32'(grant), 32'h0);
    chk("t1_busy_c4", 32'(busy), 32'd0);
    tick();
    chk("t1_valid_c5", 32'(out_valid), 32'd0);

    // Round-robin from reset with single-flit packets
    reset_pulse();
    for (int i = 0; i < NR; i++) push(i, 16'h8000 + 16'(i));
    drain(40, 1'b0);
    want.push_back(16'h8000);
    want.push_back(16'h8001);
    want.push_back(16'h8002);
    want.push_back(16'h8003);
    check_got("rr_order_a");
    push(0, 16'h8000);
    push(2, 16'h8002);
    drain(20, 1'b0);
    want.push_back(16'h8000);
    want.push_back(16'h8002);
    check_got("rr_order_b");

    // Backpressure mid-packet
    push(2, 16'h0101);
    push(2, 16'h0102);
    push(2, 16'h0103);
    push(2, 16'h8104);
    tick();
    chk("bp_grant", 32'(grant), 32'h4);
    tick();
    chk("bp_first", 32'(out_data), 32'h0101);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_hold_data", 32'(out_data), 32'h0101);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_rd_low", 32'(req_rd_en), 32'd0);
    end
    out_ready = 1'b1;
    drain(30, 1'b0);
    want.push_back(16'h0101);
    want.push_back(16'h0102);
    want.push_back(16'h0103);
    want.push_back(16'h8104);
    check_got("bp_seq");

    // Starved lock: owner FIFO runs dry mid-packet
    reset_pulse();
    push(0, 16'h0A01);
    push(3, 16'h8D01);
    tick();
    chk("sl_grant_first", 32'(grant), 32'h1);
    tick();
    chk("sl_first_flit", 32'(out_data), 32'h0A01);
    repeat (4) begin
      tick();
      chk("sl_grant_hold", 32'(grant), 32'h1);
      chk("sl_rd_low", 32'(req_rd_en), 32'd0);
      chk("sl_busy", 32'(busy), 32'd1);
    end
    push(0, 16'h8A02);
    drain(30, 1'b0);
    want.push_back(16'h0A01);
    want.push_back(16'h8A02);
    want.push_back(16'h8D01);
    check_got("sl_seq");

    // Reset mid-packet; rr_ptr first moved to 2
    push(1, 16'h8111);
    drain(20, 1'b0);
    got.delete();
    push(2, 16'h0201);
    push(2, 16'h0202);
    push(2, 16'h8203);
    tick();
    chk("mr_grant", 32'(grant), 32'h4);
    tick();
    chk("mr_first", 32'(out_data), 32'h0201);
    push(1, 16'h8111);
    rst = 1'b1;
    #1;
    chk("mr_grant_rst", 32'(grant), 32'd0);
    chk("mr_busy_rst", 32'(busy), 32'd0);
    chk("mr_valid_rst", 32'(out_valid), 32'd0);
    chk("mr_data_rst", 32'(out_data), 32'd0);
    chk("mr_rd_rst", 32'(req_rd_en), 32'd0);
    tick();
    chk("mr_fifo_kept", 32'(q[2].size()), 32'd2);
    rst = 1'b0;
    tick();
    chk("mr_grant_after", 32'(grant), 32'h2);
    drain(30, 1'b0);
    want.push_back(16'h8111);
    want.push_back(16'h0202);
    want.push_back(16'h8203);
    check_got("mr_seq");

    // Random scoreboard: flit = {tail, req[2:0], pkt[7:0], idx[3:0]}
    reset_pulse();
    total = 0;
    for (int i = 0; i < NR; i++) begin
      for (int p = 0; p < 100; p++) begin
        len = $urandom_range(1, 5);
        for (int unsigned k = 0; k < len; k++) begin
          f = {(k == len - 1), 3'(i), 8'(p), 4'(k)};
          q[i].push_back(f);
          exp_q[i].push_back(f);
          total++;
        end
      end
    end
    refresh();
    drain(20000, 1'b1);
    chk("sb_count", 32'(got.size()), 32'(total));
    owner = -1;
    for (int i = 0; i < got.size(); i++) begin
      f = got[i];
      r = int'(f[14:12]);
      if (owner >= 0) chk("sb_no_interleave", 32'(r), 32'(owner));
      if (r >= NR || exp_q[r].size() == 0) begin
        chk("sb_extra_flit", 32'(f), 32'hFFFF_FFFF);
      end else begin
        chk("sb_order", 32'(f), 32'(exp_q[r][0]));
        void'(exp_q[r].pop_front());
      end
      owner = f[15] ? -1 : r;
    end
    for (int i = 0; i < NR; i++) chk("sb_all_seen", 32'(exp_q[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
